dbus_req_ctrl: RTL and testbench

//  Sequences the memory stage's data-bus request through the dbus valid/addr_ok/data_ok handshake.

---
 rtl/dbus_req_ctrl_pkg.sv | 46 ++++
 rtl/dbus_req_ctrl.sv | 149 ++++++++++++++
 tb/tb_dbus_req_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_req_ctrl_pkg.sv
// Shared data-bus types for the memory-stage request controller:
// request/response structs, access size encoding, controller state enum
// and the address alignment helper.
package dbus_req_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } dbus_ctrl_state_t;

    // True when addr is a multiple of the access size.
    function automatic logic is_aligned(input logic [63:0] addr, input msize_t size);
        logic ok;
        case (size)
            MSIZE2:  ok = (addr[0] == 1'b0);
            MSIZE4:  ok = (addr[1:0] == 2'b00);
            MSIZE8:  ok = (addr[2:0] == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dbus_req_ctrl.sv
// Memory-stage data-bus request controller. Passes a new request through
// with zero latency, holds it stable until data_ok, stalls the pipeline
// meanwhile, buffers the response when the pipeline cannot advance, and
// drains an in-flight request after a flush.
// Optional feature: define MEM_MISALIGN_CHECK_EN to block misaligned
// accesses at issue and report them on misalign.
module dbus_req_ctrl
    import dbus_req_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  dbus_req_t        req_in,
    input  logic             advance,
    input  logic             flush,
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    output logic [63:0]      rdata,
    output logic             done,
    output logic             stall,
    output logic             misalign,
    output logic [CNT_W-1:0] stall_cnt
);

    dbus_ctrl_state_t state, state_n;
    dbus_req_t        req_q;
    logic [63:0]      data_q;
    logic             misalign_q;
    logic             capture_req;
    logic             capture_data;
    logic             mis_now;

    // addr_ok only tells us the address phase was accepted; the request is
    // held until data_ok regardless, so it drives nothing here.
    logic addr_ok_unused;
    assign addr_ok_unused = dresp.addr_ok;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_now = ~is_aligned(req_in.addr, req_in.size);
`else
    assign mis_now = 1'b0;
`endif

    // Next state and bus/pipeline outputs; everything idles while reset is high
    // so the bus side sees the abandon in the same cycle.
    always_comb begin
        state_n      = state;
        dreq         = '0;
        rdata        = '0;
        done         = 1'b0;
        stall        = 1'b0;
        misalign     = 1'b0;
        capture_req  = 1'b0;
        capture_data = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (req_in.valid && !flush) begin
                        if (mis_now) begin
                            misalign = 1'b1;
                            done     = 1'b1;
                            if (!advance) begin
                                state_n      = HOLD;
                                capture_data = 1'b1;
                            end
                        end else begin
                            dreq        = req_in;
                            capture_req = 1'b1;
                            if (dresp.data_ok) begin
                                done  = 1'b1;
                                rdata = dresp.data;
                                if (!advance) begin
                                    state_n      = HOLD;
                                    capture_data = 1'b1;
                                end
                            end else begin
                                stall   = 1'b1;
                                state_n = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    dreq = req_q;
                    if (dresp.data_ok) begin
                        if (!flush) begin
                            done  = 1'b1;
                            rdata = dresp.data;
                            if (advance) begin
                                state_n = IDLE;
                            end else begin
                                state_n      = HOLD;
                                capture_data = 1'b1;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stall = 1'b1;
                        if (flush) begin
                            state_n = DRAIN;
                        end
                    end
                end
                HOLD: begin
                    done     = 1'b1;
                    rdata    = data_q;
                    misalign = misalign_q;
                    if (advance || flush) begin
                        state_n = IDLE;
                    end
                end
                DRAIN: begin
                    dreq  = req_q;
                    stall = 1'b1;
                    if (dresp.data_ok) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, held request, buffered response and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            data_q     <= '0;
            misalign_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state <= state_n;
            if (capture_req) begin
                req_q <= req_in;
            end
            if (capture_data) begin
                data_q     <= rdata;
                misalign_q <= misalign;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Directed bench for dbus_req_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge. A 3-bit stall
// counter is used so saturation is reachable in a short run.
module tb_dbus_req_ctrl;
    import dbus_req_ctrl_pkg::*;

    localparam int unsigned CW = 3;

    logic          clk;
    logic          reset;
    dbus_req_t     req_in;
    logic          advance;
    logic          flush;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic [63:0]   rdata;
    logic          done;
    logic          stall;
    logic          misalign;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    dbus_req_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .advance   (advance),
        .flush     (flush),
        .dreq      (dreq),
        .dresp     (dresp),
        .rdata     (rdata),
        .done      (done),
        .stall     (stall),
        .misalign  (misalign),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [63:0] a, input msize_t s,
                           input logic [7:0] st, input logic [63:0] d);
        req_in.valid  = v;
        req_in.addr   = a;
        req_in.size   = s;
        req_in.strobe = st;
        req_in.data   = d;
    endtask

    task automatic set_resp(input logic ok, input logic [63:0] d);
        dresp.addr_ok = ok;
        dresp.data_ok = ok;
        dresp.data    = d;
    endtask

    initial begin
        reset   = 1'b1;
        advance = 1'b0;
        flush   = 1'b0;
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        tick();
        tick();
        @(negedge clk);
        check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_rdata", rdata, 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);

        // 1: load with data_ok in the issue cycle, pipeline advancing
        tick();
        set_req(1'b1, 64'h8000_0000, MSIZE8, 8'hFF, 64'h0);
        set_resp(1'b1, 64'h1122_3344_5566_7788);
        advance = 1'b1;
        @(negedge clk);
        check("t1_dreq_valid", 64'(dreq.valid), 64'd1);
        check("t1_dreq_addr", dreq.addr, 64'h8000_0000);
        check("t1_done", 64'(done), 64'd1);
        check("t1_rdata", rdata, 64'h1122_3344_5566_7788);
        check("t1_stall", 64'(stall), 64'd0);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        @(negedge clk);
        check("t1_state", 64'(dut.state), 64'(IDLE));
        check("t1_done_after", 64'(done), 64'd0);
        check("t1_cnt", 64'(stall_cnt), 64'd0);

        // 2: store, data_ok three cycles after issue; request must stay put
        tick();
        set_req(1'b1, 64'h8000_0010, MSIZE4, 8'h0F, 64'hCAFE);
        @(negedge clk);
        check("t2_stall_c0", 64'(stall), 64'd1);
        check("t2_addr_c0", dreq.addr, 64'h8000_0010);
        tick();
        set_req(1'b1, 64'h9999_0000, MSIZE1, 8'h01, 64'h1234);
        @(negedge clk);
        check("t2_stall_c1", 64'(stall), 64'd1);
        check("t2_addr_c1", dreq.addr, 64'h8000_0010);
        check("t2_data_c1", dreq.data, 64'hCAFE);
        check("t2_strobe_c1", 64'(dreq.strobe), 64'h0F);
        tick();
        @(negedge clk);
        check("t2_stall_c2", 64'(stall), 64'd1);
        check("t2_valid_c2", 64'(dreq.valid), 64'd1);
        tick();
        set_resp(1'b1, 64'h0);
        @(negedge clk);
        check("t2_done", 64'(done), 64'd1);
        check("t2_stall_c3", 64'(stall), 64'd0);
        check("t2_addr_c3", dreq.addr, 64'h8000_0010);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        @(negedge clk);
        check("t2_cnt", 64'(stall_cnt), 64'd3);
        check("t2_state", 64'(dut.state), 64'(IDLE));

        // 3: data_ok while pipeline is held -> response buffered in HOLD
        tick();
        set_req(1'b1, 64'h100, MSIZE8, 8'hFF, 64'h0);
        set_resp(1'b1, 64'hDEAD_BEEF);
        advance = 1'b0;
        @(negedge clk);
        check("t3_done_c0", 64'(done), 64'd1);
        check("t3_rdata_c0", rdata, 64'hDEAD_BEEF);
        tick();
        set_resp(1'b0, 64'h5555);
        @(negedge clk);
        check("t3_state", 64'(dut.state), 64'(HOLD));
        check("t3_rdata_c1", rdata, 64'hDEAD_BEEF);
        check("t3_done_c1", 64'(done), 64'd1);
        check("t3_valid_c1", 64'(dreq.valid), 64'd0);
        check("t3_stall_c1", 64'(stall), 64'd0);
        tick();
        advance = 1'b1;
        @(negedge clk);
        check("t3_rdata_c2", rdata, 64'hDEAD_BEEF);
        check("t3_valid_c2", 64'(dreq.valid), 64'd0);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        advance = 1'b0;
        @(negedge clk);
        check("t3_back_idle", 64'(dut.state), 64'(IDLE));
        check("t3_done_c3", 64'(done), 64'd0);

        // 4: flush in WAIT, data_ok two cycles later -> DRAIN then IDLE
        tick();
        set_req(1'b1, 64'h200, MSIZE8, 8'hFF, 64'h0);
        @(negedge clk);
        check("t4_stall_c0", 64'(stall), 64'd1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("t4_stall_c1", 64'(stall), 64'd1);
        check("t4_done_c1", 64'(done), 64'd0);
        tick();
        flush = 1'b0;
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        @(negedge clk);
        check("t4_state", 64'(dut.state), 64'(DRAIN));
        check("t4_stall_c2", 64'(stall), 64'd1);
        check("t4_done_c2", 64'(done), 64'd0);
        check("t4_addr_c2", dreq.addr, 64'h200);
        tick();
        set_resp(1'b1, 64'h77);
        advance = 1'b1;
        @(negedge clk);
        check("t4_done_c3", 64'(done), 64'd0);
        check("t4_stall_c3", 64'(stall), 64'd1);
        tick();
        set_resp(1'b0, 64'h0);
        @(negedge clk);
        check("t4_idle", 64'(dut.state), 64'(IDLE));
        check("t4_stall_c4", 64'(stall), 64'd0);
        check("t4_cnt", 64'(stall_cnt), 64'd7);

        // 5: counter saturates, then reset in WAIT clears everything
        tick();
        set_req(1'b1, 64'h300, MSIZE8, 8'hFF, 64'h0);
        tick();
        @(negedge clk);
        check("t5_cnt_sat", 64'(stall_cnt), 64'd7);
        check("t5_in_wait", 64'(dut.state), 64'(WAIT));
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", 64'(dreq.valid), 64'd0);
        check("t5_rst_stall", 64'(stall), 64'd0);
        tick();
        reset = 1'b0;
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        @(negedge clk);
        check("t5_state", 64'(dut.state), 64'(IDLE));
        check("t5_cnt", 64'(stall_cnt), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_stall", 64'(stall), 64'd0);
        check("t5_valid", 64'(dreq.valid), 64'd0);
        check("t5_rdata", rdata, 64'd0);

        // 6: misaligned word access
        tick();
        set_req(1'b1, 64'h1002, MSIZE4, 8'h0F, 64'h0);
        advance = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        check("t6_misalign", 64'(misalign), 64'd1);
        check("t6_done", 64'(done), 64'd1);
        check("t6_valid", 64'(dreq.valid), 64'd0);
        check("t6_stall", 64'(stall), 64'd0);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        @(negedge clk);
        check("t6_idle", 64'(dut.state), 64'(IDLE));
        check("t6_mis_clr", 64'(misalign), 64'd0);
        tick();
        set_req(1'b1, 64'h1001, MSIZE2, 8'h03, 64'h0);
        advance = 1'b0;
        @(negedge clk);
        check("t6_mis_h0", 64'(misalign), 64'd1);
        tick();
        advance = 1'b1;
        @(negedge clk);
        check("t6_hold", 64'(dut.state), 64'(HOLD));
        check("t6_mis_h1", 64'(misalign), 64'd1);
        check("t6_done_h1", 64'(done), 64'd1);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        @(negedge clk);
        check("t6_idle2", 64'(dut.state), 64'(IDLE));
`else
        @(negedge clk);
        check("t6_misalign", 64'(misalign), 64'd0);
        check("t6_valid", 64'(dreq.valid), 64'd1);
        check("t6_addr", dreq.addr, 64'h1002);
        check("t6_stall", 64'(stall), 64'd1);
        tick();
        set_req(1'b0, 64'h0, MSIZE1, 8'h0, 64'h0);
        set_resp(1'b1, 64'h0);
        @(negedge clk);
        check("t6_done", 64'(done), 64'd1);
        check("t6_misalign2", 64'(misalign), 64'd0);
        tick();
        set_resp(1'b0, 64'h0);
        @(negedge clk);
        check("t6_idle", 64'(dut.state), 64'(IDLE));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
